// File: rtl/brq_pkg.sv
// Shared types for the brq EXU iterative multiply/divide unit.
// Ports: none (package: op encoding, FSM states, is_div helper).
package brq_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_iter_op_e;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_PREP,
        MD_ITER,
        MD_FIXUP,
        MD_DONE
    } md_iter_fsm_e;

    function automatic logic is_div(input md_iter_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/brq_exu_md_addsub.sv
// Add/subtract with carry-out for the multiply/divide unit.
// Ports: a, b operands; sub selects a - b; sum result; carry out.
module brq_exu_md_addsub #(
    parameter int unsigned N = 35
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         carry
);

    logic [N-1:0] b_eff;

    assign b_eff = sub ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, b_eff}
                        + {{N{1'b0}}, sub};

endmodule

// File: rtl/brq_exu_multdiv_iter.sv
// Iterative RV M-extension multiply/divide unit with its own adder.
// Ports: clk_i, rst_ni; request valid_i/ready_o/op_i/op_a_i/op_b_i/
// data_ind_timing_i; kill_i; response valid_o/ready_i/result_o.
module brq_exu_multdiv_iter
    import brq_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_BITS = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  md_iter_op_e      op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             data_ind_timing_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned AW    = WIDTH + MUL_BITS + 1;
    localparam int unsigned PW    = WIDTH + MUL_BITS;
    localparam int unsigned CW    = $clog2(WIDTH);
    localparam int unsigned ITERS = WIDTH / MUL_BITS;

    md_iter_fsm_e       state_q, state_d;
    md_iter_op_e        op_q;
    logic               dit_q, sa_q, res_neg_q;
    logic [WIDTH-1:0]   a_q, b_q, rem_q, res_q;
    logic [2*WIDTH-1:0] acc_q, acc_nxt;
    logic [CW-1:0]      cnt_q, shift;

    logic               sgn_a, sgn_b, sa, sb;
    logic               b_zero, res_neg, dz_fast;
    logic               div_q, is_mulh, last;
    logic [MUL_BITS-1:0] digit;
    logic [PW-1:0]      pp, acc_win;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   lo, hi, hi_inv, fix_val;
    logic [AW-1:0]      add_a, add_b, add_sum;
    logic               add_sub, add_co, unused_top;

    // Request decode, evaluated against the inputs at the accept edge.
    assign sgn_a   = op_i inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    assign sgn_b   = op_i inside {MD_MULH, MD_DIV, MD_REM};
    assign sa      = sgn_a & op_a_i[WIDTH-1];
    assign sb      = sgn_b & op_b_i[WIDTH-1];
    assign b_zero  = (op_b_i == '0);
    assign dz_fast = is_div(op_i) & b_zero & ~data_ind_timing_i;

    // Quotient sign is dropped for a zero divisor so it stays all ones.
    always_comb begin
        res_neg = sa ^ sb;
        if (is_div(op_i)) begin
            res_neg = op_i[1] ? sa : ((sa ^ sb) & ~b_zero);
        end
    end

    assign div_q   = is_div(op_q);
    assign is_mulh = op_q inside {MD_MULH, MD_MULHSU, MD_MULHU};
    assign lo      = acc_q[WIDTH-1:0];
    assign hi      = acc_q[2*WIDTH-1:WIDTH];
    assign hi_inv  = ~hi;
    assign rem_sh  = {rem_q, a_q[WIDTH-1]};
    assign digit   = b_q[MUL_BITS-1:0];

    // Bits above the current window are still zero, so the window sum
    // never carries out of PW bits.
    assign shift   = div_q ? '0
                   : CW'((ITERS - 1 - int'(cnt_q)) * MUL_BITS);
    assign acc_win = acc_q[shift +: PW];

    assign last = (cnt_q == '0)
                | (~div_q & ~dit_q & ((b_q >> MUL_BITS) == '0));

    always_comb begin
        pp = '0;
        for (int j = 0; j < int'(MUL_BITS); j++) begin
            pp = pp + ({PW{digit[j]}} & (PW'(a_q) << j));
        end
    end

    always_comb begin
        acc_nxt = acc_q;
        acc_nxt[shift +: PW] = add_sum[PW-1:0];
    end

    always_comb begin
        fix_val = a_q;
        unique case (op_q)
            MD_MUL:                       fix_val = lo;
            MD_MULH, MD_MULHSU, MD_MULHU: fix_val = hi;
            MD_REM, MD_REMU:              fix_val = rem_q;
            default:                      fix_val = a_q;
        endcase
    end

    // Adder operand selection per state.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                add_b   = AW'(op_b_i);
                add_sub = 1'b1;
            end
            MD_PREP: begin
                add_b   = AW'(a_q);
                add_sub = 1'b1;
            end
            MD_ITER: begin
                if (div_q) begin
                    add_a   = AW'(rem_sh);
                    add_b   = AW'(b_q);
                    add_sub = 1'b1;
                end else begin
                    add_a = AW'(acc_win);
                    add_b = AW'(pp);
                end
            end
            MD_FIXUP: begin
                // High half of -x is ~hi plus the carry out of ~lo + 1.
                if (is_mulh) begin
                    add_a = AW'(hi_inv);
                    add_b = AW'(lo == '0);
                end else begin
                    add_b   = AW'(fix_val);
                    add_sub = 1'b1;
                end
            end
            default: ;
        endcase
    end

    brq_exu_md_addsub #(.N(AW)) u_addsub (
        .a     (add_a),
        .b     (add_b),
        .sub   (add_sub),
        .sum   (add_sum),
        .carry (add_co)
    );

    assign unused_top = add_sum[AW-1];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_IDLE: begin
                if (valid_i) state_d = dz_fast ? MD_DONE : MD_PREP;
            end
            MD_PREP:  state_d = MD_ITER;
            MD_ITER:  if (last) state_d = MD_FIXUP;
            MD_FIXUP: state_d = MD_DONE;
            MD_DONE:  if (ready_i) state_d = MD_IDLE;
            default:  state_d = MD_IDLE;
        endcase
        if (kill_i && state_q != MD_IDLE) state_d = MD_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q      <= MD_MUL;
            dit_q     <= 1'b0;
            sa_q      <= 1'b0;
            res_neg_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            res_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (valid_i) begin
                        op_q      <= op_i;
                        dit_q     <= data_ind_timing_i;
                        sa_q      <= sa;
                        res_neg_q <= res_neg;
                        a_q       <= op_a_i;
                        b_q       <= sb ? add_sum[WIDTH-1:0] : op_b_i;
                        rem_q     <= '0;
                        acc_q     <= '0;
                        res_q     <= op_i[1] ? op_a_i : '1;
                    end
                end
                MD_PREP: begin
                    if (sa_q) a_q <= add_sum[WIDTH-1:0];
                    cnt_q <= div_q ? CW'(WIDTH - 1) : CW'(ITERS - 1);
                end
                MD_ITER: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (div_q) begin
                        rem_q <= add_co ? add_sum[WIDTH-1:0]
                                        : rem_sh[WIDTH-1:0];
                        a_q   <= {a_q[WIDTH-2:0], add_co};
                    end else begin
                        acc_q <= acc_nxt;
                        b_q   <= b_q >> MUL_BITS;
                    end
                end
                MD_FIXUP: begin
                    res_q <= res_neg_q ? add_sum[WIDTH-1:0] : fix_val;
                end
                default: ;
            endcase
        end
    end

    assign ready_o  = (state_q == MD_IDLE);
    assign valid_o  = (state_q == MD_DONE);
    assign result_o = valid_o ? res_q : '0;

endmodule

// File: tb/tb_brq_exu_multdiv_iter.sv
// Directed bench for brq_exu_multdiv_iter (32/2 and 16/4 instances).
// Ports: none.
module tb_brq_exu_multdiv_iter;
    import brq_pkg::*;

    logic        clk_i   = 1'b0;
    logic        rst_ni  = 1'b0;
    logic        valid_i = 1'b0;
    logic        dit     = 1'b0;
    logic        kill_i  = 1'b0;
    logic        ready_i = 1'b1;
    logic        sel     = 1'b0;
    md_iter_op_e op_i    = MD_MUL;
    logic [31:0] op_a_i  = '0;
    logic [31:0] op_b_i  = '0;

    logic        rdy_w, vld_w, rdy_n, vld_n;
    logic [31:0] res_w;
    logic [15:0] res_n;
    logic        obs_valid, obs_ready;
    logic [31:0] obs_res;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    brq_exu_multdiv_iter #(.WIDTH(32), .MUL_BITS(2)) dut_w (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .valid_i           (valid_i & ~sel),
        .ready_o           (rdy_w),
        .op_i              (op_i),
        .op_a_i            (op_a_i),
        .op_b_i            (op_b_i),
        .data_ind_timing_i (dit),
        .kill_i            (kill_i & ~sel),
        .valid_o           (vld_w),
        .ready_i           (ready_i),
        .result_o          (res_w)
    );

    brq_exu_multdiv_iter #(.WIDTH(16), .MUL_BITS(4)) dut_n (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .valid_i           (valid_i & sel),
        .ready_o           (rdy_n),
        .op_i              (op_i),
        .op_a_i            (op_a_i[15:0]),
        .op_b_i            (op_b_i[15:0]),
        .data_ind_timing_i (dit),
        .kill_i            (kill_i & sel),
        .valid_o           (vld_n),
        .ready_i           (ready_i),
        .result_o          (res_n)
    );

    assign obs_valid = sel ? vld_n : vld_w;
    assign obs_ready = sel ? rdy_n : rdy_w;
    assign obs_res   = sel ? {16'h0, res_n} : res_w;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input md_iter_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic d);
        op_i    = op;
        op_a_i  = a;
        op_b_i  = b;
        dit     = d;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!obs_valid && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input md_iter_op_e op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic d, input logic [31:0] exp,
                          input int lat);
        int n;
        issue(op, a, b, d);
        wait_valid(n);
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_res"}, 64'(obs_res), 64'(exp));
        @(posedge clk_i);
        #1;
        check({tag, "_idle"}, 64'({obs_ready, obs_valid}), 64'(2'b10));
    endtask

    task automatic kill_then_divu(input string tag, input int lat);
        logic seen;
        issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk_i);
        #1;
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        check({tag, "_kill"}, 64'({obs_ready, obs_valid}), 64'(2'b10));
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (obs_valid) seen = 1'b1;
        end
        check({tag, "_stale"}, 64'(seen), 64'(0));
        run_op({tag, "_divu"}, MD_DIVU, 32'd100, 32'd7, 1'b0, 32'd14, lat);
    endtask

    initial begin
        int  n;
        logic seen;
        #12;
        check("rst_async", 64'({obs_ready, obs_valid, obs_res}),
              64'({1'b1, 1'b0, 32'h0}));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("rst_state", 64'({obs_ready, obs_valid, obs_res}),
              64'({1'b1, 1'b0, 32'h0}));

        run_op("mulhsu", MD_MULHSU, 32'hFFFFFFFF, 32'h2, 1'b1,
               32'hFFFFFFFF, 19);
        run_op("mul_ee", MD_MUL, 32'd7, 32'd1, 1'b0, 32'd7, 4);
        run_op("mul_dit", MD_MUL, 32'd7, 32'd1, 1'b1, 32'd7, 19);
        run_op("mul_neg", MD_MUL, 32'hFFFFFFFD, 32'd5, 1'b0,
               32'hFFFFFFF1, 5);
        run_op("mulh_neg", MD_MULH, 32'hFFFFFFFD, 32'd5, 1'b1,
               32'hFFFFFFFF, 19);
        run_op("mulh_pos", MD_MULH, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0,
               32'h0, 4);
        run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0,
               32'h80000000, 35);
        run_op("rem_ovf", MD_REM, 32'h80000000, 32'hFFFFFFFF, 1'b0,
               32'h0, 35);
        run_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0,
               32'hFFFFFFFD, 35);
        run_op("divu_dz", MD_DIVU, 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 1);
        run_op("div_dz", MD_DIV, 32'hFFFFFFFB, 32'd0, 1'b0,
               32'hFFFFFFFF, 1);
        run_op("div_dz_dit", MD_DIV, 32'hFFFFFFFB, 32'd0, 1'b1,
               32'hFFFFFFFF, 35);
        run_op("rem_dz_dit", MD_REM, 32'hFFFFFFFB, 32'd0, 1'b1,
               32'hFFFFFFFB, 35);

        ready_i = 1'b0;
        issue(MD_REM, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_valid(n);
        check("hold_lat", 64'(n), 64'(35));
        repeat (10) begin
            check("hold", 64'({obs_valid, obs_ready, obs_res}),
                  64'({1'b1, 1'b0, 32'hFFFFFFFF}));
            @(posedge clk_i);
            #1;
        end
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("hold_ret", 64'({obs_ready, obs_valid, obs_res}),
              64'({1'b1, 1'b0, 32'h0}));

        kill_then_divu("w32", 35);

        issue(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        repeat (4) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_mid", 64'({obs_ready, obs_valid, obs_res}),
              64'({1'b1, 1'b0, 32'h0}));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk_i);
            #1;
            if (obs_valid) seen = 1'b1;
        end
        check("rst_noval", 64'(seen), 64'(0));
        run_op("mulhu", MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
               32'hFFFFFFFE, 19);

        sel = 1'b1;
        #1;
        kill_then_divu("w16", 19);
        run_op("w16_mulhsu", MD_MULHSU, 32'hFFFF, 32'h2, 1'b1,
               32'hFFFF, 7);
        run_op("w16_mul_ee", MD_MUL, 32'd7, 32'd1, 1'b0, 32'd7, 4);
        run_op("w16_div_ovf", MD_DIV, 32'h8000, 32'hFFFF, 1'b0,
               32'h8000, 19);
        run_op("w16_rem", MD_REM, 32'hFFF9, 32'd2, 1'b0, 32'hFFFF, 19);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
